// File: rtl/gate_sweep_pkg.sv
// rtl/gate_sweep_pkg.sv - shared state encoding and sizing helper for the gate sweep sequencer
//
// Purpose: holds the sweep FSM state type and the hold-counter width function
// used by the sequencer top and its settle timer.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } sweep_state_e;

    // Bits needed to hold the value holdCycles; never narrower than one bit.
    function automatic int holdWidth(input int holdCycles);
        return (holdCycles < 1) ? 1 : $clog2(holdCycles + 1);
    endfunction

endpackage

// File: rtl/gate_sweep_timer.sv
// rtl/gate_sweep_timer.sv - loadable settle down-counter for the gate sweep sequencer
//
// Purpose: after a load, raises tick during the HOLD_CYCLES-th cycle so the
// caller can leave its settle state after exactly HOLD_CYCLES cycles.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   load   in  restart the count at HOLD_CYCLES
//   tick   out settle period has elapsed (one cycle wide)
module gate_sweep_timer
    import gate_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tick
);

    localparam int W = holdWidth(HOLD_CYCLES);
    localparam logic [W-1:0] LOAD_VAL = W'(HOLD_CYCLES);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Count reads HOLD_CYCLES in the first cycle after load, so it reads 1
    // in the last settle cycle; it parks at 0 so tick stays a single pulse.
    assign tick = (count == W'(1));

endmodule

// File: rtl/gate_sweep_sequencer.sv
// rtl/gate_sweep_sequencer.sv - exhaustive input sweep and truth-table checker for a small gate DUT
//
// Purpose: on start, drives every vector 0..2**N_IN-1 onto the DUT, lets each
// settle HOLD_CYCLES cycles, compares dut_y with EXPECT[vector], and reports
// pass, mismatch count and the first failing vector.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, abort     begin a sweep when idle / cancel a running sweep
//   vec_out          stimulus to the DUT inputs
//   dut_y            DUT output
//   busy, done       sweep in progress / one-cycle completion pulse
//   pass             last completed sweep had zero mismatches
//   err_count        mismatches in the last or current sweep
//   first_err_vec    first mismatching vector, valid when first_err_valid
module gate_sweep_sequencer
    import gate_sweep_pkg::*;
#(
    parameter int                  N_IN        = 3,
    parameter int                  HOLD_CYCLES = 1,
    parameter logic [2**N_IN-1:0]  EXPECT      = 8'h80
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_valid
);

    sweep_state_e state;
    sweep_state_e nextState;

    // A start seen in IDLE is registered here; the sweep is initialised on the
    // following edge, which puts done 1 + 2**N_IN*(HOLD_CYCLES+1) cycles after
    // the accepting edge while every vector still gets HOLD_CYCLES+1 cycles.
    logic armed;
    logic timerLoad;
    logic tick;
    logic mismatch;
    logic lastVec;
    logic sampleCommit;

    assign mismatch     = (dut_y != EXPECT[vec_out]);
    assign lastVec      = (vec_out == {N_IN{1'b1}});
    // abort in the sample cycle discards that comparison
    assign sampleCommit = (state == S_SAMPLE) && !abort;

    gate_sweep_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) holdTimer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (timerLoad),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:   if (armed) nextState = S_SETTLE;
            S_SETTLE: begin
                if (abort)     nextState = S_IDLE;
                else if (tick) nextState = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort)        nextState = S_IDLE;
                else if (lastVec) nextState = S_DONE;
                else              nextState = S_SETTLE;
            end
            S_DONE:   nextState = S_IDLE;
            default:  nextState = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = armed || (state == S_SETTLE) || (state == S_SAMPLE);
        done      = (state == S_DONE);
        timerLoad = ((state == S_IDLE) && armed) ||
                    ((state == S_SAMPLE) && (nextState == S_SETTLE));
    end

    // Vector counter and scoreboard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed           <= 1'b0;
            vec_out         <= '0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
        end else begin
            armed <= (state == S_IDLE) && !armed && start;
            if ((state == S_IDLE) && armed) begin
                vec_out         <= '0;
                err_count       <= '0;
                first_err_valid <= 1'b0;
                pass            <= 1'b0;
            end else if (sampleCommit) begin
                if (mismatch) begin
                    err_count <= err_count + 1'b1;
                    if (!first_err_valid) begin
                        first_err_vec   <= vec_out;
                        first_err_valid <= 1'b1;
                    end
                end
                // the terminal vector is not incremented; it stays on the DUT
                if (lastVec) begin
                    pass <= !mismatch && (err_count == '0);
                end else begin
                    vec_out <= vec_out + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_sweep_sequencer.sv
// tb/tb_gate_sweep_sequencer.sv - table-driven and randomized bench for gate_sweep_sequencer
module tb_gate_sweep_sequencer;

    localparam int NIN   = 3;
    localparam int HOLD  = 2;
    localparam int NVEC  = 1 << NIN;
    localparam int SWEEP = NVEC * (HOLD + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, start, abort, start1, abort1;
    logic [NIN-1:0] vec_out, vec_out1, first_err_vec, first_err_vec1;
    logic           dut_y, dut_y1, busy, busy1, done, done1, pass, pass1;
    logic           first_err_valid, first_err_valid1;
    logic [NIN:0]   err_count, err_count1;
    logic [7:0]     lut;
    logic [7:0]     gold = 8'h80;

    // Gate under test is a truth table the bench chooses; the sequencer expects AND.
    assign dut_y  = lut[vec_out];
    assign dut_y1 = gold[vec_out1];

    gate_sweep_sequencer #(.N_IN(NIN), .HOLD_CYCLES(HOLD), .EXPECT(8'h80)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_out(vec_out),
        .dut_y(dut_y), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
    );

    gate_sweep_sequencer #(.N_IN(NIN), .HOLD_CYCLES(1), .EXPECT(8'h80)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .vec_out(vec_out1),
        .dut_y(dut_y1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
        .first_err_vec(first_err_vec1), .first_err_valid(first_err_valid1)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: mismatches of table l against AND over the first nv vectors.
    function automatic int refErrs(input logic [7:0] l, input int nv);
        int c = 0;
        for (int v = 0; v < nv; v++) if (l[v] != gold[v]) c++;
        return c;
    endfunction

    function automatic int refFirst(input logic [7:0] l, input int nv);
        for (int v = 0; v < nv; v++) if (l[v] != gold[v]) return v;
        return -1;
    endfunction

    // One sweep on the HOLD=2 instance. pokeK/abortK: cycle after the
    // accepting edge during which start/abort is held high (0 = never).
    task automatic runSweep(input logic [7:0] l, input int pokeK, input int abortK,
                            input int expErrs, input int expFirst, input string tag);
        int seqErr = 0;
        int doneAt = 0;
        int doneCnt = 0;
        int busyAtDone = 0;
        int passAtDone = 0;
        int busyLate = 0;
        int lateFrom;
        lateFrom = (abortK != 0) ? abortK : SWEEP;
        lut = l;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            start = (k == pokeK);
            abort = (k == abortK);
            @(negedge clk);
            if (k <= SWEEP && (abortK == 0 || k <= abortK)) begin
                if (int'(vec_out) != (k - 1) / (HOLD + 1) || !busy) seqErr++;
            end
            if (done) begin
                doneCnt++;
                if (doneAt == 0) begin
                    doneAt = k;
                    busyAtDone = busy;
                    passAtDone = pass;
                end
            end
            if (k > lateFrom && busy) busyLate++;
        end
        start = 1'b0;
        abort = 1'b0;
        check($sformatf("%s_vec_sequence", tag), seqErr, 0);
        check($sformatf("%s_busy_after_end", tag), busyLate, 0);
        if (abortK == 0) begin
            check($sformatf("%s_done_cycle", tag), doneAt, SWEEP + 1);
            check($sformatf("%s_done_count", tag), doneCnt, 1);
            check($sformatf("%s_pass_at_done", tag), passAtDone, int'(expErrs == 0));
            check($sformatf("%s_busy_at_done", tag), busyAtDone, 0);
        end else begin
            check($sformatf("%s_no_done_after_abort", tag), doneCnt, 0);
        end
        check($sformatf("%s_err_count", tag), err_count, expErrs);
        check($sformatf("%s_first_valid", tag), first_err_valid, int'(expFirst >= 0));
        if (expFirst >= 0) check($sformatf("%s_first_vec", tag), first_err_vec, expFirst);
        check($sformatf("%s_pass_hold", tag), pass, int'(abortK == 0 && expErrs == 0));
    endtask

    typedef struct {
        logic [7:0] lut;
        int         poke;
        int         errs;
        int         first;
        string      name;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [7:0] rl;
        int ab, pk, nv;
        int d1, d2, cnt, vecHold, busyHold;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        lut = 8'h80;
        tbl[0] = '{8'h80,  0, 0, -1, "and"};
        tbl[1] = '{8'h00,  7, 1,  7, "stuck0"};
        tbl[2] = '{8'hFE, 25, 6,  1, "or"};
        tbl[3] = '{8'h96,  0, 3,  1, "xor"};
        tbl[4] = '{8'h7F, 12, 8,  0, "nand"};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_pass", pass, 0);
        check("reset_err_count", err_count, 0);
        check("reset_vec_out", vec_out, 0);
        check("reset_first", {first_err_valid, first_err_vec}, 0);
        check("reset_busy_h1", busy1, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++)
            runSweep(tbl[i].lut, tbl[i].poke, 0, tbl[i].errs, tbl[i].first, tbl[i].name);

        // abort in the first settle cycle of vector 4 with an OR gate, then rerun
        runSweep(8'hFE, 0, 13, 3, 1, "abort_v4");
        runSweep(8'hFE, 0, 0, 6, 1, "restart_after_abort");
        // abort during the sample of the final vector discards that sample
        runSweep(8'h00, 0, SWEEP, 0, -1, "abort_last_sample");

        // asynchronous reset in the middle of vector 5
        lut = 8'hFE;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check("pre_reset_vec", vec_out, 5);
        check("pre_reset_err_count", err_count, 4);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {busy, done, pass, err_count, vec_out, first_err_valid, first_err_vec}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        runSweep(8'h80, 0, 0, 0, -1, "after_reset");

        // start held high on the HOLD=1 instance
        d1 = 0; d2 = 0; cnt = 0; vecHold = -1; busyHold = -1;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done1) begin
                cnt++;
                if (d1 == 0) d1 = k;
                else if (d2 == 0) d2 = k;
            end
            if (k == 18) begin
                vecHold = vec_out1;
                busyHold = busy1;
            end
            if (k == 20) start1 = 1'b0;
        end
        check("held_start_first_done", d1, 17);
        check("held_start_idle_vec_hold", vecHold, 7);
        check("held_start_idle_busy", busyHold, 0);
        check("held_start_second_done", d2, 36);
        check("held_start_done_count", cnt, 2);
        check("held_start_pass", pass1, 1);

        // randomized truth tables, start pokes and aborts against the reference
        for (int i = 0; i < 20; i++) begin
            rl = 8'($urandom);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, SWEEP)) : 0;
            if (ab != 0) pk = (ab > 1) ? int'($urandom_range(0, ab - 1)) : 0;
            else         pk = int'($urandom_range(0, SWEEP + 1));
            nv = (ab != 0) ? (ab - 1) / (HOLD + 1) : NVEC;
            runSweep(rl, pk, ab, refErrs(rl, nv), refFirst(rl, nv), $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
